// File: rtl/sorted_index_drain.sv
// rtl/sorted_index_drain.sv - captures four values and drains their indices in sorted order
// Optional build macro: SORT_DESCENDING_EN (largest-first drain order)
module sorted_index_drain #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic         idle,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   out_index,
   output logic [W-1:0] out_value,
   output logic         out_last
);

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_DRAIN = 1'b1;

   logic                state_q, state_d;
   logic [3:0]          remaining_q, remaining_d;
   logic [3:0][W-1:0]   val_q, val_d;

   logic [1:0]          sel_index;
   logic [W-1:0]        sel_value;
   logic                sel_found;
   logic                one_left;
   logic                xfer;

   // True when candidate x should displace the current pick y; strict so ties keep the lower index
   function automatic logic beats(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SORT_DESCENDING_EN
      return x > y;
`else
      return x < y;
`endif
   endfunction

   // Scan remaining entries from index 0 upward and keep the best one seen so far
   always_comb begin
      sel_index = 2'd0;
      sel_value = '0;
      sel_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (remaining_q[i] && (!sel_found || beats(val_q[i], sel_value))) begin
            sel_found = 1'b1;
            sel_index = 2'(i);
            sel_value = val_q[i];
         end
      end
   end

   // Output decode is purely from registers so no input ever reaches an output combinationally
   always_comb begin
      one_left  = (remaining_q != 4'd0) && ((remaining_q & (remaining_q - 4'd1)) == 4'd0);
      idle      = (state_q == S_IDLE);
      out_valid = (state_q == S_DRAIN);
      out_index = out_valid ? sel_index : 2'd0;
      out_value = out_valid ? sel_value : '0;
      out_last  = out_valid && one_left;
      xfer      = out_valid && out_ready;
   end

   // Next-state: capture on load in IDLE, retire the selected entry on each transfer in DRAIN
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      val_d       = val_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               val_d       = {d, c, b, a};
               remaining_d = 4'b1111;
               state_d     = S_DRAIN;
            end
         end
         default: begin
            if (xfer) begin
               remaining_d = remaining_q & ~(4'b0001 << sel_index);
               if (one_left) begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // State registers with synchronous active-high reset discarding any partial set
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= 4'd0;
         val_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         val_q       <= val_d;
      end
   end

endmodule

// File: tb/tb_sorted_index_drain.sv
// tb/tb_sorted_index_drain.sv - scoreboard bench for sorted_index_drain
module tb_sorted_index_drain;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [2:0] a = '0, b = '0, c = '0, d = '0;
   logic       idle, out_valid, out_last;
   logic       out_ready = 1'b0;
   logic [1:0] out_index;
   logic [2:0] out_value;

   int n_tests = 0;
   int n_fail  = 0;

   // {last, index, value}
   logic [5:0] exp_q[$];

   sorted_index_drain #(.W(3)) dut (
      .clk(clk), .reset(reset), .load(load),
      .a(a), .b(b), .c(c), .d(d),
      .idle(idle), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_value(out_value), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp4(input logic [1:0] i0, input logic [2:0] v0,
                       input logic [1:0] i1, input logic [2:0] v1,
                       input logic [1:0] i2, input logic [2:0] v2,
                       input logic [1:0] i3, input logic [2:0] v3);
      exp_q.push_back({1'b0, i0, v0});
      exp_q.push_back({1'b0, i1, v1});
      exp_q.push_back({1'b0, i2, v2});
      exp_q.push_back({1'b1, i3, v3});
   endtask

   task automatic do_load(input logic [2:0] va, input logic [2:0] vb,
                          input logic [2:0] vc, input logic [2:0] vd);
      @(posedge clk); #1;
      a = va; b = vb; c = vc; d = vd; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic wait_drain(input bit toggle, input string name);
      int i;
      for (i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
         out_ready = toggle ? ~out_ready : 1'b1;
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
      check({name, "_idle_after"}, {idle, out_valid}, 2'b10);
   endtask

   // Monitor: every accepted entry must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_xfer", {out_last, out_index, out_value}, 6'h3f);
         end else begin
            check("scoreboard", {out_last, out_index, out_value}, exp_q.pop_front());
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {idle, out_valid, out_index, out_value, out_last}, {1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
      @(posedge clk); #1;
      reset = 1'b0;

      // Basic ascending drain
      out_ready = 1'b1;
`ifdef SORT_DESCENDING_EN
      exp4(2'd2, 3'd7, 2'd0, 3'd5, 2'd1, 3'd2, 2'd3, 3'd1);
`else
      exp4(2'd3, 3'd1, 2'd1, 3'd2, 2'd0, 3'd5, 2'd2, 3'd7);
`endif
      do_load(3'd5, 3'd2, 3'd7, 3'd1);
      wait_drain(1'b0, "basic");

      // Ties resolve to the lowest index
`ifdef SORT_DESCENDING_EN
      exp4(2'd0, 3'd4, 2'd1, 3'd4, 2'd3, 3'd4, 2'd2, 3'd0);
`else
      exp4(2'd2, 3'd0, 2'd0, 3'd4, 2'd1, 3'd4, 2'd3, 3'd4);
`endif
      do_load(3'd4, 3'd4, 3'd0, 3'd4);
      wait_drain(1'b0, "ties");

      // Back-pressure: hold, then toggle ready
`ifdef SORT_DESCENDING_EN
      exp4(2'd1, 3'd6, 2'd0, 3'd3, 2'd2, 3'd1, 2'd3, 3'd0);
`else
      exp4(2'd3, 3'd0, 2'd2, 3'd1, 2'd0, 3'd3, 2'd1, 3'd6);
`endif
      out_ready = 1'b0;
      do_load(3'd3, 3'd6, 3'd1, 3'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
`ifdef SORT_DESCENDING_EN
         check("bp_hold", {out_valid, out_index, out_value}, {1'b1, 2'd1, 3'd6});
`else
         check("bp_hold", {out_valid, out_index, out_value}, {1'b1, 2'd3, 3'd0});
`endif
      end
      wait_drain(1'b1, "backpressure");
      out_ready = 1'b1;

      // Load during drain is ignored
`ifdef SORT_DESCENDING_EN
      exp4(2'd1, 3'd3, 2'd2, 3'd2, 2'd3, 3'd1, 2'd0, 3'd0);
`else
      exp4(2'd0, 3'd0, 2'd3, 3'd1, 2'd2, 3'd2, 2'd1, 3'd3);
`endif
      do_load(3'd0, 3'd3, 3'd2, 3'd1);
      a = 3'd7; b = 3'd7; c = 3'd7; d = 3'd7; load = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      load = 1'b0;
      wait_drain(1'b0, "load_in_drain");
      @(negedge clk);
      check("load_in_drain_stays_idle", {idle, out_valid}, 2'b10);

      // Reset mid-drain after two transfers
`ifdef SORT_DESCENDING_EN
      exp_q.push_back({1'b0, 2'd2, 3'd7});
      exp_q.push_back({1'b0, 2'd0, 3'd5});
`else
      exp_q.push_back({1'b0, 2'd3, 3'd1});
      exp_q.push_back({1'b0, 2'd1, 3'd2});
`endif
      do_load(3'd5, 3'd2, 3'd7, 3'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs", {idle, out_valid, out_index, out_value, out_last}, {1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
      check("mid_reset_two_xfers", exp_q.size(), 0);
      exp_q.delete();
      out_ready = 1'b1;
      exp4(2'd0, 3'd1, 2'd1, 3'd1, 2'd2, 3'd1, 2'd3, 3'd1);
      do_load(3'd1, 3'd1, 3'd1, 3'd1);
      wait_drain(1'b0, "after_reset");

      // Back-to-back sets with load in the first idle cycle
`ifdef SORT_DESCENDING_EN
      exp4(2'd2, 3'd7, 2'd0, 3'd5, 2'd1, 3'd2, 2'd3, 3'd1);
      exp4(2'd0, 3'd6, 2'd2, 3'd3, 2'd3, 3'd3, 2'd1, 3'd0);
`else
      exp4(2'd3, 3'd1, 2'd1, 3'd2, 2'd0, 3'd5, 2'd2, 3'd7);
      exp4(2'd1, 3'd0, 2'd2, 3'd3, 2'd3, 3'd3, 2'd0, 3'd6);
`endif
      do_load(3'd5, 3'd2, 3'd7, 3'd1);
      begin
         bit seen_last;
         seen_last = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
               seen_last = 1'b1;
               break;
            end
         end
         check("b2b_last_seen", seen_last, 1'b1);
      end
      @(posedge clk); #1;
      a = 3'd6; b = 3'd0; c = 3'd3; d = 3'd3; load = 1'b1;
      @(negedge clk);
      check("b2b_idle_turnaround", {idle, out_valid}, 2'b10);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      check("b2b_no_bubble", out_valid, 1'b1);
      wait_drain(1'b0, "b2b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
